// File: rtl/disp_pkg.sv
// Purpose : shared types and constants for the display BCD formatter.
// Latency : n/a (types, constants and a combinational blanking helper).
// Backpr. : n/a.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    localparam int BCD_W   = 4;              // bits per BCD digit
    localparam int DIGITS  = 4;              // digits per display field
    localparam int FIELD_W = BCD_W * DIGITS; // bits per packed BCD field

    localparam logic [BCD_W-1:0] BLANK_NIBBLE = '0;

    // One display field after blanking: packed digits plus per-digit enables.
    typedef struct packed {
        logic [FIELD_W-1:0] dat;
        logic [DIGITS-1:0]  able;
    } field_t;

    // Leading-zero blanking: walk from the most significant digit down; once a
    // nonzero digit has been seen every lower digit stays lit. Digit 0 is always
    // lit so a zero amount still shows "0". A disabled field is fully dark.
    function automatic field_t blank_field(input logic en, input logic [FIELD_W-1:0] bcd);
        field_t f;
        logic   seen;
        f    = '0;
        seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen = seen | (bcd[k*BCD_W +: BCD_W] != BLANK_NIBBLE) | (k == 0);
            if (en && seen) begin
                f.able[k]              = 1'b1;
                f.dat[k*BCD_W +: BCD_W] = bcd[k*BCD_W +: BCD_W];
            end else begin
                f.dat[k*BCD_W +: BCD_W] = BLANK_NIBBLE;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// Purpose : one double-dabble iteration: add 3 to every BCD nibble >= 5, then
//           shift {bcd, bin} left by one bit.
// Latency : combinational. Backpr.: none.
// Ports   : bcd_i/bin_i current accumulator and remaining binary; bcd_o/bin_o next.
module bin2bcd_step
    import disp_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic [FIELD_W-1:0] bcd_i,
    input  logic [WIDTH-1:0]   bin_i,
    output logic [FIELD_W-1:0] bcd_o,
    output logic [WIDTH-1:0]   bin_o
);

    logic [FIELD_W-1:0] adj;

    always_comb begin
        adj = bcd_i;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_i[k*BCD_W +: BCD_W] >= BCD_W'(5)) begin
                adj[k*BCD_W +: BCD_W] = bcd_i[k*BCD_W +: BCD_W] + BCD_W'(3);
            end
        end
        // The top BCD bit falls off; it is never set for inputs <= 9999.
        {bcd_o, bin_o} = {adj, bin_i} << 1;
    end

endmodule

// File: rtl/disp_bcd_formatter.sv
// Purpose : converts two binary amounts to 4-digit BCD fields with saturation,
//           leading-zero blanking and field enables, for the 8-digit driver.
// Latency : update sampled at edge N, outputs/done registered at edge N+WIDTH+1.
// Backpr. : none; update while busy is remembered (pending) and restarts at commit.
// Ports   : clk/rst (sync, active-high); left_val/right_val, left_en/right_en, update
//           in; dispdata, seg_able, ovf, done (1-cycle pulse), busy out.
module disp_bcd_formatter
    import disp_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int MAXVAL = 9999
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     left_val,
    input  logic [WIDTH-1:0]     right_val,
    input  logic                 left_en,
    input  logic                 right_en,
    input  logic                 update,
    output logic [2*FIELD_W-1:0] dispdata,
    output logic [2*DIGITS-1:0]  seg_able,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           ovf
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAXVAL);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     lbin_q, lbin_d, rbin_q, rbin_d;
    logic [FIELD_W-1:0]   lbcd_q, lbcd_d, rbcd_q, rbcd_d;
    logic [1:0]           clamp_q, clamp_d;
    logic [1:0]           en_q, en_d;
    logic                 pend_q, pend_d;
    logic [2*FIELD_W-1:0] disp_q, disp_d;
    logic [2*DIGITS-1:0]  able_q, able_d;
    logic [1:0]           ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic [FIELD_W-1:0]   lbcd_nx, rbcd_nx;
    logic [WIDTH-1:0]     lbin_nx, rbin_nx;
    logic                 capture;
    logic                 lclamp, rclamp;
    field_t               lfld, rfld;

    bin2bcd_step #(.WIDTH(WIDTH)) u_step_left (
        .bcd_i (lbcd_q),
        .bin_i (lbin_q),
        .bcd_o (lbcd_nx),
        .bin_o (lbin_nx)
    );

    bin2bcd_step #(.WIDTH(WIDTH)) u_step_right (
        .bcd_i (rbcd_q),
        .bin_i (rbin_q),
        .bcd_o (rbcd_nx),
        .bin_o (rbin_nx)
    );

    assign lclamp = (left_val  > MAX_W);
    assign rclamp = (right_val > MAX_W);

    // Blanking works on the finished accumulators and the enables captured with
    // the values, so each commit reflects one consistent input snapshot.
    assign lfld = blank_field(en_q[1], lbcd_q);
    assign rfld = blank_field(en_q[0], rbcd_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lbin_d  = lbin_q;
        rbin_d  = rbin_q;
        lbcd_d  = lbcd_q;
        rbcd_d  = rbcd_q;
        clamp_d = clamp_q;
        en_d    = en_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        able_d  = able_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        capture = 1'b0;

        case (state_q)
            ST_IDLE: begin
                capture = update;
            end
            ST_SHIFT: begin
                lbcd_d = lbcd_nx;
                lbin_d = lbin_nx;
                rbcd_d = rbcd_nx;
                rbin_d = rbin_nx;
                cnt_d  = cnt_q + CNT_W'(1);
                pend_d = pend_q | update;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_d  = {lfld.dat, rfld.dat};
                able_d  = {lfld.able, rfld.able};
                ovf_d   = clamp_q;
                done_d  = 1'b1;
                pend_d  = 1'b0;
                state_d = ST_IDLE;
                // A request that arrived during the conversion (or is present
                // now) starts the next one without dropping busy.
                capture = pend_q | update;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            lbin_d  = lclamp ? MAX_W : left_val;
            rbin_d  = rclamp ? MAX_W : right_val;
            clamp_d = {lclamp, rclamp};
            en_d    = {left_en, right_en};
            lbcd_d  = '0;
            rbcd_d  = '0;
            cnt_d   = '0;
            state_d = ST_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lbin_q  <= '0;
            rbin_q  <= '0;
            lbcd_q  <= '0;
            rbcd_q  <= '0;
            clamp_q <= '0;
            en_q    <= '0;
            pend_q  <= 1'b0;
            disp_q  <= '0;
            able_q  <= '0;
            ovf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lbin_q  <= lbin_d;
            rbin_q  <= rbin_d;
            lbcd_q  <= lbcd_d;
            rbcd_q  <= rbcd_d;
            clamp_q <= clamp_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            able_q  <= able_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign dispdata = disp_q;
    assign seg_able = able_q;
    assign ovf      = ovf_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_disp_bcd_formatter.sv
// Purpose : self-checking bench for disp_bcd_formatter with a scoreboard queue.
// Latency : expects commit WIDTH+1 edges after the sampled update.
// Backpr. : n/a.
module tb_disp_bcd_formatter;

    localparam int W = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  left_val, right_val;
    logic          left_en, right_en, update;
    logic [31:0]   dispdata;
    logic [7:0]    seg_able;
    logic          busy, done;
    logic [1:0]    ovf;

    typedef struct {
        logic [31:0] disp;
        logic [7:0]  able;
        logic [1:0]  ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] hold_disp = '0;
    logic [7:0]  hold_able = '0;
    logic [1:0]  hold_ovf  = '0;

    disp_bcd_formatter #(.WIDTH(W), .MAXVAL(9999)) dut (
        .clk       (clk),
        .rst       (rst),
        .left_val  (left_val),
        .right_val (right_val),
        .left_en   (left_en),
        .right_en  (right_en),
        .update    (update),
        .dispdata  (dispdata),
        .seg_able  (seg_able),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: counts edges, applies the reset model, pops the scoreboard on done
    // and otherwise insists the outputs hold their last committed values.
    initial begin
        logic rst_s;
        exp_t e;
        forever begin
            @(posedge clk);
            rst_s = rst;
            cyc++;
            #1;
            if (rst_s) begin
                sb.delete();
                hold_disp = '0;
                hold_able = '0;
                hold_ovf  = '0;
                chk("rst_dispdata", dispdata, 32'h0);
                chk("rst_seg_able", {24'h0, seg_able}, 32'h0);
                chk("rst_ovf", {30'h0, ovf}, 32'h0);
                chk("rst_busy", {31'h0, busy}, 32'h0);
                chk("rst_done", {31'h0, done}, 32'h0);
            end else if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", {31'h0, done}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("dispdata", dispdata, e.disp);
                    chk("seg_able", {24'h0, seg_able}, {24'h0, e.able});
                    chk("ovf", {30'h0, ovf}, {30'h0, e.ovf});
                    chk("done_cycle", cyc, e.cyc);
                    hold_disp = e.disp;
                    hold_able = e.able;
                    hold_ovf  = e.ovf;
                end
            end else begin
                chk("hold_dispdata", dispdata, hold_disp);
                chk("hold_seg_able", {24'h0, seg_able}, {24'h0, hold_able});
                chk("hold_ovf", {30'h0, ovf}, {30'h0, hold_ovf});
            end
        end
    end

    task automatic start(input int lv, input int rv, input logic le, input logic re,
                         input logic [31:0] d, input logic [7:0] a, input logic [1:0] o,
                         output int n);
        exp_t e;
        @(negedge clk);
        left_val  = W'(lv);
        right_val = W'(rv);
        left_en   = le;
        right_en  = re;
        update    = 1'b1;
        n         = cyc + 1;
        e.disp = d; e.able = a; e.ovf = o; e.cyc = n + W + 1;
        sb.push_back(e);
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [7:0] a, input logic [1:0] o,
                            input int c);
        exp_t e;
        e.disp = d; e.able = a; e.ovf = o; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", {31'h0, busy}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; update = 1'b0;
        left_val = '0; right_val = '0; left_en = 1'b1; right_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1234 / 56 with busy window N..N+14
        start(1234, 56, 1'b1, 1'b1, 32'h1234_0056, 8'hF3, 2'b00, n);
        while (cyc <= n + W + 1) begin
            chk("busy_window", {31'h0, busy}, {31'h0, (cyc <= n + W)});
            @(negedge clk);
        end
        wait_idle();

        // zero amounts keep digit 0 lit
        start(0, 0, 1'b1, 1'b1, 32'h0, 8'h11, 2'b00, n);
        wait_idle();

        // left clamps, right exactly at the limit does not
        start(12000, 9999, 1'b1, 1'b1, 32'h9999_9999, 8'hFF, 2'b10, n);
        wait_idle();

        // right one above the limit
        start(9999, 10000, 1'b1, 1'b1, 32'h9999_9999, 8'hFF, 2'b01, n);
        wait_idle();

        // left field disabled
        start(77, 305, 1'b0, 1'b1, 32'h0000_0305, 8'h07, 2'b00, n);
        wait_idle();

        // right field disabled
        start(4000, 8, 1'b1, 1'b0, 32'h4000_0000, 8'hF0, 2'b00, n);
        wait_idle();

        // update during conversion becomes pending, restart at commit
        start(0, 10, 1'b1, 1'b1, 32'h0000_0010, 8'h13, 2'b00, n);
        repeat (4) @(negedge clk);
        right_val = W'(20);
        update    = 1'b1;
        push_exp(32'h0000_0020, 8'h13, 2'b00, n + 2 * (W + 1));
        @(negedge clk);
        update = 1'b0;
        while (cyc <= n + 2 * (W + 1)) begin
            chk("busy_pending", {31'h0, busy}, {31'h0, (cyc <= n + 2 * (W + 1) - 1)});
            @(negedge clk);
        end
        wait_idle();

        // update held high: back-to-back conversions
        @(negedge clk);
        left_val = W'(500); right_val = W'(7);
        update   = 1'b1;
        n        = cyc + 1;
        push_exp(32'h0500_0007, 8'h71, 2'b00, n + W + 1);
        push_exp(32'h0500_0007, 8'h71, 2'b00, n + 2 * (W + 1));
        repeat (W + 2) @(negedge clk);
        update = 1'b0;
        wait_idle();

        // reset during a conversion discards it
        start(42, 42, 1'b1, 1'b1, 32'h0042_0042, 8'h33, 2'b00, n);
        wait_idle();
        start(99, 99, 1'b1, 1'b1, 32'h0099_0099, 8'h33, 2'b00, n);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("busy_after_rst", {31'h0, busy}, 32'h0);
        start(99, 99, 1'b1, 1'b1, 32'h0099_0099, 8'h33, 2'b00, n);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_bcd_formatter.md
Name: disp_bcd_formatter

Overview:
- Upstream stage of the 8-digit seven-segment driver in the vending machine datapath.
- Takes two binary amounts and converts each to 4 BCD digits with a sequential double-dabble converter: left field (digits 7..4, e.g. coins paid) and right field (digits 3..0, e.g. price or change).
- Applies per-field leading-zero blanking and per-field enable.
- Presents registered `dispdata[31:0]` and `seg_able[7:0]` that connect directly to the driver's inputs.

Parameters:
- WIDTH, 14, bit width of each binary input value; legal range 14..16.
- MAXVAL, 9999, saturation limit per field.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- left_val  input  WIDTH  binary amount for digits 7..4
- right_val  input  WIDTH  binary amount for digits 3..0
- left_en  input  1  0 = blank entire left field
- right_en  input  1  0 = blank entire right field
- update  input  1  request conversion of current inputs (level or pulse)
- dispdata  output  32  packed BCD; nibble i = digit i, digit 0 rightmost
- seg_able  output  8  digit enable; bit i enables nibble i
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse when outputs are updated
- ovf  output  2  [1]=left clamped, [0]=right clamped; registered with dispdata

Behaviour:
- Reset (sync, rst=1 at edge) forces the following regardless of state; in-flight conversion is discarded:
  - dispdata=0, seg_able=0, busy=0, done=0, ovf=0, pending=0, state=IDLE.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE with update=1 at edge N:
  - Capture both fields, clamped to MAXVAL when value > MAXVAL, and set the clamp flags.
  - Clear the 16-bit BCD accumulators, cnt=0.
  - Go to SHIFT; busy=1 from edge N.
- SHIFT, edges N+1..N+WIDTH, one double-dabble iteration per edge on both fields in parallel:
  - Each BCD nibble >=5 gets +3.
  - Then shift {bcd,bin} left by 1.
  - cnt increments; at cnt==WIDTH-1 go to COMMIT.
- COMMIT, edge N+WIDTH+1:
  - Register dispdata, seg_able, ovf; done=1 for exactly this cycle.
  - busy=0 unless restarting.
  - Latency: update sampled at N, results visible after edge N+15 for WIDTH=14.
- Blanking, per field, with digits d3..d0:
  - en=0: all 4 enable bits 0 and nibbles forced to 0.
  - en=1: digit k enabled iff any of d3..dk is nonzero; digit 0 always enabled.
  - Blanked nibbles are forced to 0.
- update while busy (SHIFT or COMMIT) sets pending.
  - In COMMIT with pending=1 (or update=1), restart immediately: capture live inputs, clear pending, go to SHIFT. busy stays 1.
  - done still pulses for the completed conversion.
- update held high in IDLE: conversions run back-to-back, one done per WIDTH+1 cycles.
- Outputs hold their last committed values between conversions. No change is visible mid-conversion.
- Clamp compare is unsigned on the full WIDTH; value exactly MAXVAL does not set ovf.

Decomposition:
- Shared package `disp_pkg` holds:
  - FSM state enum (IDLE/SHIFT/COMMIT).
  - BCD digit width constant (4).
  - Digits-per-field constant (4).
  - Blank-nibble constant.
- Sub-module `bin2bcd_step`: purely combinational single double-dabble iteration (add-3 on 4 nibbles then shift), instantiated twice (left/right).
- Top level owns the FSM, counter, accumulator registers, clamping, blanking and output registers.

Test Plan:
- left=1234, right=56, both en=1, update pulse at N -> after edge N+15: dispdata=32'h1234_0056, seg_able=8'hF3, ovf=0, done high one cycle; busy high N..N+14.
- left=0, right=0, en=1 -> dispdata=0, seg_able=8'h11 (digit 0 of each field only).
- left=12000, right=9999 -> dispdata=32'h9999_9999, seg_able=8'hFF, ovf=2'b10.
- left_en=0, left=77, right=305 -> dispdata=32'h0000_0305, seg_able=8'h07.
- update pulses at N and N+5 with right changed 10->20 between them:
  - first done at N+15 shows right=10;
  - second conversion starts N+15, done at N+30 showing 20;
  - busy continuous from N through N+29.
- Convert 42/42 and commit, then start 99/99 and assert rst at N+7 -> next cycle all outputs 0, no done pulse; a subsequent update converts normally.
